// File: rtl/ysyx_25040109_mux_key_with_default_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040109_mux_key_with_default_pkg
// Description : Shared constants for the key/data lookup multiplexer.
//               Reset values of the capture registers live here so that the
//               top level and any future users agree on them.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_25040109_mux_key_with_default_pkg;

    // Value held by hit_q while reset is asserted. The data register always
    // resets to all zeros regardless of its width.
    localparam logic HIT_RESET_VAL = 1'b0;

endpackage : ysyx_25040109_mux_key_with_default_pkg
`default_nettype wire

// File: rtl/ysyx_25040109_mux_key_internal.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040109_mux_key_internal
// Description : Purely combinational key lookup with default. Every pair key
//               is compared against the input key in parallel; the highest
//               matching pair index wins, and default_out is driven on a miss.
// Ports       : key         (in)  lookup key, KEY_LEN bits
//               lut         (in)  packed {key,data} pairs, pair i at
//                                 [PAIR_LEN*(i+1)-1 : PAIR_LEN*i]
//               default_out (in)  value driven when nothing matches
//               out         (out) selected data
//               hit         (out) high when any pair key equals key
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040109_mux_key_internal
    import ysyx_25040109_mux_key_with_default_pkg::*;
#(
    parameter  int NR_KEY   = 2,
    parameter  int KEY_LEN  = 1,
    parameter  int DATA_LEN = 1,
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN,
    localparam int LUT_LEN  = NR_KEY * PAIR_LEN
) (
    input  logic [KEY_LEN-1:0]  key,
    input  logic [LUT_LEN-1:0]  lut,
    input  logic [DATA_LEN-1:0] default_out,
    output logic [DATA_LEN-1:0] out,
    output logic                hit
);

    logic [KEY_LEN-1:0]  pair_key   [NR_KEY];
    logic [DATA_LEN-1:0] pair_data  [NR_KEY];
    logic [NR_KEY-1:0]   pair_match;

    // Split the packed table into per-pair key/data fields and compare.
    generate
        for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_unpack
            assign pair_key[gi]   = lut[PAIR_LEN*gi + DATA_LEN +: KEY_LEN];
            assign pair_data[gi]  = lut[PAIR_LEN*gi +: DATA_LEN];
            assign pair_match[gi] = (pair_key[gi] == key);
        end
    endgenerate

    // Ascending scan: a later (higher-index) match overwrites an earlier one,
    // giving priority to the highest index. A lower-index pair carrying X/Z
    // can never overwrite the result once a defined higher pair has matched.
    always_comb begin
        out = default_out;
        hit = 1'b0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (pair_match[i]) begin
                out = pair_data[i];
                hit = 1'b1;
            end
        end
    end

endmodule : ysyx_25040109_mux_key_internal
`default_nettype wire

// File: rtl/ysyx_25040109_mux_key_with_default.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040109_mux_key_with_default
// Description : Key lookup multiplexer with default value. The lookup result
//               (out/hit) is combinational; out_q/hit_q are one-cycle
//               registered copies captured when en is high.
// Ports       : clk         (in)  rising-edge clock
//               rst_n       (in)  asynchronous active-low reset of out_q/hit_q
//               key         (in)  lookup key, KEY_LEN bits
//               default_out (in)  value driven when nothing matches
//               lut         (in)  packed {key,data} table, NR_KEY pairs
//               en          (in)  capture enable for out_q/hit_q
//               out         (out) combinational lookup result
//               hit         (out) combinational match flag
//               out_q       (out) registered out
//               hit_q       (out) registered hit
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040109_mux_key_with_default
    import ysyx_25040109_mux_key_with_default_pkg::*;
#(
    parameter  int NR_KEY   = 2,
    parameter  int KEY_LEN  = 1,
    parameter  int DATA_LEN = 1,
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN,
    localparam int LUT_LEN  = NR_KEY * PAIR_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_LEN-1:0]  key,
    input  logic [DATA_LEN-1:0] default_out,
    input  logic [LUT_LEN-1:0]  lut,
    input  logic                en,
    output logic [DATA_LEN-1:0] out,
    output logic                hit,
    output logic [DATA_LEN-1:0] out_q,
    output logic                hit_q
);

    logic [DATA_LEN-1:0] out_d;
    logic                hit_d;

    ysyx_25040109_mux_key_internal #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_lookup (
        .key         (key),
        .lut         (lut),
        .default_out (default_out),
        .out         (out),
        .hit         (hit)
    );

    // Load on enable, otherwise recirculate.
    always_comb begin
        out_d = out_q;
        hit_d = hit_q;
        if (en) begin
            out_d = out;
            hit_d = hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            hit_q <= HIT_RESET_VAL;
        end else begin
            out_q <= out_d;
            hit_q <= hit_d;
        end
    end

endmodule : ysyx_25040109_mux_key_with_default
`default_nettype wire

// File: tb/tb_ysyx_25040109_mux_key_with_default.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25040109_mux_key_with_default
// Description : Directed testbench. Stimulus pushes hand-computed expected
//               values into a scoreboard queue; a monitor process pops and
//               compares whenever a sample is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040109_mux_key_with_default;

    localparam logic [116:0] LUT_BASE = {7'h17, 32'h8000_0000, 7'h37, 32'h0000_0000, 7'h6F, 32'h8000_0010};
    localparam logic [116:0] LUT_DUP  = {7'h17, 32'h8000_0000, 7'h37, 32'h0000_0000, 7'h17, 32'hFFFF_FFFF};

    // sel: 0 = main comb, 1 = main reg, 2 = single-pair comb, 3 = single-pair reg
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] data;
        logic        hit;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [6:0]   key;
    logic [31:0]  default_out;
    logic [116:0] lut;
    logic [31:0]  out;
    logic         hit;
    logic [31:0]  out_q;
    logic         hit_q;

    logic [3:0]   key1;
    logic [7:0]   default_out1;
    logic [11:0]  lut1;
    logic [7:0]   out1;
    logic         hit1;
    logic [7:0]   out_q1;
    logic         hit_q1;

    exp_t sb[$];
    event ev_check;
    int   n_assert;
    int   n_fail;

    ysyx_25040109_mux_key_with_default #(
        .NR_KEY (3), .KEY_LEN (7), .DATA_LEN (32)
    ) dut (
        .clk (clk), .rst_n (rst_n), .key (key), .default_out (default_out),
        .lut (lut), .en (en), .out (out), .hit (hit), .out_q (out_q), .hit_q (hit_q)
    );

    ysyx_25040109_mux_key_with_default #(
        .NR_KEY (1), .KEY_LEN (4), .DATA_LEN (8)
    ) dut1 (
        .clk (clk), .rst_n (rst_n), .key (key1), .default_out (default_out1),
        .lut (lut1), .en (en), .out (out1), .hit (hit1), .out_q (out_q1), .hit_q (hit_q1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string name, input int sel, input logic [31:0] data, input logic h);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.data = data;
        e.hit  = h;
        sb.push_back(e);
    endtask

    task automatic check_now();
        -> ev_check;
        #1;
    endtask

    // Monitor: drains the scoreboard whenever a sample is presented.
    initial begin
        n_assert = 0;
        n_fail   = 0;
        forever begin
            @(ev_check);
            while (sb.size() > 0) begin
                exp_t        e;
                logic [31:0] act_d;
                logic        act_h;
                e = sb.pop_front();
                case (e.sel)
                    0:       begin act_d = out;            act_h = hit;    end
                    1:       begin act_d = out_q;          act_h = hit_q;  end
                    2:       begin act_d = {24'h0, out1};   act_h = hit1;   end
                    default: begin act_d = {24'h0, out_q1}; act_h = hit_q1; end
                endcase
                n_assert++;
                if (act_d !== e.data) begin
                    n_fail++;
                    $display("FAIL %s data: got %h expected %h", e.name, act_d, e.data);
                end
                n_assert++;
                if (act_h !== e.hit) begin
                    n_fail++;
                    $display("FAIL %s hit: got %b expected %b", e.name, act_h, e.hit);
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        en           = 1'b0;
        key          = 7'h17;
        default_out  = 32'h1234_5678;
        lut          = LUT_BASE;
        key1         = 4'hA;
        default_out1 = 8'h11;
        lut1         = {4'hA, 8'h5C};

        // Reset state; combinational path alive during reset.
        #2;
        expect_val("reset_comb",     0, 32'h8000_0000, 1'b1);
        expect_val("reset_reg",      1, 32'h0,         1'b0);
        expect_val("reset_comb_n1",  2, 32'h5C,        1'b1);
        expect_val("reset_reg_n1",   3, 32'h0,         1'b0);
        check_now();

        // First capture after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        @(posedge clk); #1;
        expect_val("cap_hit17",      1, 32'h8000_0000, 1'b1);
        expect_val("cap_n1",         3, 32'h5C,        1'b1);
        check_now();

        // Miss drives default; default change follows immediately.
        @(negedge clk);
        key  = 7'h33;
        key1 = 4'hB;
        #1;
        expect_val("miss_default",   0, 32'h1234_5678, 1'b0);
        expect_val("miss_n1",        2, 32'h11,        1'b0);
        check_now();
        default_out = 32'hDEAD_BEEF;
        #1;
        expect_val("default_follow", 0, 32'hDEAD_BEEF, 1'b0);
        check_now();
        @(posedge clk); #1;
        expect_val("cap_miss",       1, 32'hDEAD_BEEF, 1'b0);
        check_now();

        // Zero data is a hit, not a miss.
        @(negedge clk);
        key = 7'h37;
        #1;
        expect_val("zero_data",      0, 32'h0, 1'b1);
        check_now();
        @(posedge clk); #1;
        expect_val("cap_zero_data",  1, 32'h0, 1'b1);
        check_now();

        // Lowest pair lookup.
        @(negedge clk);
        key = 7'h6F;
        #1;
        expect_val("pair0",          0, 32'h8000_0010, 1'b1);
        check_now();

        // Duplicate key: highest index wins; old pair0 key now misses.
        lut = LUT_DUP;
        key = 7'h17;
        #1;
        expect_val("dup_priority",   0, 32'h8000_0000, 1'b1);
        check_now();
        key = 7'h6F;
        #1;
        expect_val("dup_old_miss",   0, 32'hDEAD_BEEF, 1'b0);
        check_now();

        // Capture a known value, then hold with en=0.
        lut = LUT_BASE;
        key = 7'h17;
        @(posedge clk); #1;
        expect_val("cap_before_hold", 1, 32'h8000_0000, 1'b1);
        check_now();
        @(negedge clk);
        en  = 1'b0;
        key = 7'h33;
        @(posedge clk); #1;
        expect_val("hold1_reg",      1, 32'h8000_0000, 1'b1);
        expect_val("hold1_comb",     0, 32'hDEAD_BEEF, 1'b0);
        check_now();
        @(negedge clk);
        key = 7'h37;
        @(posedge clk); #1;
        expect_val("hold2_reg",      1, 32'h8000_0000, 1'b1);
        check_now();

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("async_rst_reg",  1, 32'h0, 1'b0);
        expect_val("async_rst_comb", 0, 32'h0, 1'b1);
        check_now();

        // Registers stay cleared across an enabled edge while in reset.
        @(negedge clk);
        en  = 1'b1;
        key = 7'h6F;
        @(posedge clk); #1;
        expect_val("rst_held_reg",   1, 32'h0, 1'b0);
        expect_val("rst_held_comb",  0, 32'h8000_0010, 1'b1);
        check_now();

        // Release and capture on the first edge.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_val("release_cap",    1, 32'h8000_0010, 1'b1);
        check_now();

        #10;
        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_ysyx_25040109_mux_key_with_default
`default_nettype wire
